// File: rtl/burst_sweep_ctrl.sv
// Exhaustive burst-error sweep sequencer for a combinational (N,K) burst-correcting codec pair.
// Applies every B-bit burst pattern at every offset to the captured codeword and tallies decode failures.
module burst_sweep_ctrl #(
  parameter int N      = 28,
  parameter int K      = 16,
  parameter int B      = 5,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop_on_fail,
  input  logic [0:K-1]   msg_in,
  output logic [0:K-1]   enc_msg,
  input  logic [0:N-1]   enc_cw,
  output logic [0:N-1]   dec_cw,
  input  logic [0:K-1]   dec_msg,
  output logic           busy,
  output logic           done,
  output logic [9:0]     trial_count,
  output logic [9:0]     err_count,
  output logic           fail_valid,
  output logic [4:0]     fail_off,
  output logic [B-1:0]   fail_pat
);

  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CAPTURE, S_APPLY, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [0:K-1]    msg_ref;
  logic [0:N-1]    cw_ref;
  logic [0:N-1]    mask;
  logic [4:0]      off;
  logic [B-1:0]    pat;
  logic            stop_ref;
  logic [WW-1:0]   wait_cnt;
  logic            trial_fail;
  logic            last_trial;
  logic            wait_last;

  // Pattern MSB lands on the lowest codeword index of the burst window.
  assign mask       = {pat, {(N-B){1'b0}}} >> off;
  assign trial_fail = (dec_msg != msg_ref);
  assign last_trial = (off == 5'(N-B)) && (pat == '1);
  assign wait_last  = (wait_cnt == WW'(SETTLE-1));
  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_CAPTURE;
      S_CAPTURE:      state_nxt = S_APPLY;
      S_APPLY:        state_nxt = S_WAIT;
      S_WAIT:         if (wait_last) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (last_trial || (stop_ref && trial_fail)) ? S_DONE : S_APPLY;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_msg     <= '0;
      msg_ref     <= '0;
      cw_ref      <= '0;
      dec_cw      <= '0;
      stop_ref    <= 1'b0;
      off         <= '0;
      pat         <= '0;
      wait_cnt    <= '0;
      trial_count <= '0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_off    <= '0;
      fail_pat    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            enc_msg     <= msg_in;
            msg_ref     <= msg_in;
            stop_ref    <= stop_on_fail;
            off         <= '0;
            pat         <= '0;
            trial_count <= '0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_off    <= '0;
            fail_pat    <= '0;
          end
        end
        S_CAPTURE: cw_ref <= enc_cw;
        S_APPLY: begin
          dec_cw   <= cw_ref ^ mask;
          wait_cnt <= '0;
        end
        S_WAIT: wait_cnt <= wait_cnt + 1'b1;
        S_CHECK: begin
          trial_count <= trial_count + 10'd1;
          if (trial_fail) begin
            err_count <= err_count + 10'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_off   <= off;
              fail_pat   <= pat;
            end
          end
          pat <= pat + 1'b1;
          if (pat == '1) off <= off + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
